// File: rtl/mlp_infer_ctrl_if.sv
// Request, datapath and response signals of the MLP inference controller.
// The controller connects through the slave modport; the host side uses master.
interface mlp_infer_ctrl_if #(
    parameter int IDX_W      = 10,
    parameter int CLS_W      = 9,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [IDX_W-1:0]      req_m;
    logic [IDX_W-1:0]      req_n;
    logic [IDX_W-1:0]      req_k;
    logic                  abort;
    logic [IDX_W-1:0]      dp_m_index;
    logic [IDX_W-1:0]      dp_n_index;
    logic [IDX_W-1:0]      dp_k_index;
    logic                  dp_read_enable;
    logic                  sm_done;
    logic [CLS_W-1:0]      sm_addr;
    logic [DATA_WIDTH-1:0] sm_value;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [CLS_W-1:0]      rsp_index;
    logic [DATA_WIDTH-1:0] rsp_value;
    logic                  rsp_timeout;
    logic                  busy;

    modport slave (
        input  req_valid, req_m, req_n, req_k, abort, sm_done, sm_value, rsp_ready,
        output req_ready, dp_m_index, dp_n_index, dp_k_index, dp_read_enable,
               sm_addr, rsp_valid, rsp_index, rsp_value, rsp_timeout, busy
    );

    modport master (
        output req_valid, req_m, req_n, req_k, abort, sm_done, sm_value, rsp_ready,
        input  req_ready, dp_m_index, dp_n_index, dp_k_index, dp_read_enable,
               sm_addr, rsp_valid, rsp_index, rsp_value, rsp_timeout, busy
    );
endinterface

// File: rtl/mlp_infer_ctrl.sv
// Sequences one MLP inference (lookup, compute, softmax wait) and then runs a
// one-element-per-cycle argmax scan over the softmax outputs.
//
//   state   | meaning
//   IDLE    | ready for a request
//   LOOKUP  | embedding read enabled for EMB_LAT cycles
//   COMPUTE | layer1/ReLU/layer2 settling for CMP_LAT cycles
//   SM_WAIT | waiting for sm_done, bounded by SM_TIMEOUT
//   SCAN    | argmax over softmax elements, one per cycle
//   RESP    | result offered until rsp handshake
module mlp_infer_ctrl #(
    parameter int EMB_LAT     = 2,
    parameter int CMP_LAT     = 9,
    parameter int SM_TIMEOUT  = 1023,
    parameter int NUM_CLASSES = 387,
    parameter int IDX_W       = 10,
    parameter int CLS_W       = 9,
    parameter int DATA_WIDTH  = 8
) (
    input logic              clk,
    input logic              reset,
    mlp_infer_ctrl_if.slave  bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOOKUP  = 3'd1;
    localparam logic [2:0] COMPUTE = 3'd2;
    localparam logic [2:0] SM_WAIT = 3'd3;
    localparam logic [2:0] SCAN    = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    localparam int CNT_W  = $clog2(EMB_LAT + CMP_LAT + 1);
    localparam int WCNT_W = $clog2(SM_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  EMB_LOAD  = CNT_W'(EMB_LAT - 1);
    localparam logic [CNT_W-1:0]  CMP_LOAD  = CNT_W'(CMP_LAT - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SM_TIMEOUT - 1);
    localparam logic [CLS_W-1:0]  CLS_LAST  = CLS_W'(NUM_CLASSES - 1);

    logic [2:0]            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [WCNT_W-1:0]     wcnt_q,      wcnt_d;
    logic [CLS_W-1:0]      addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] max_val_q,   max_val_d;
    logic [CLS_W-1:0]      max_idx_q,   max_idx_d;
    logic [IDX_W-1:0]      m_q,         m_d;
    logic [IDX_W-1:0]      n_q,         n_d;
    logic [IDX_W-1:0]      k_q,         k_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [CLS_W-1:0]      rsp_index_q, rsp_index_d;
    logic [DATA_WIDTH-1:0] rsp_value_q, rsp_value_d;
    logic                  rsp_tmo_q,   rsp_tmo_d;
    logic                  gt;

    // Strict compare keeps the lowest index on ties.
    assign gt = bus.sm_value > max_val_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        max_val_d   = max_val_q;
        max_idx_d   = max_idx_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        rsp_valid_d = rsp_valid_q;
        rsp_index_d = rsp_index_q;
        rsp_value_d = rsp_value_q;
        rsp_tmo_d   = rsp_tmo_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    m_d     = bus.req_m;
                    n_d     = bus.req_n;
                    k_d     = bus.req_k;
                    cnt_d   = EMB_LOAD;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = CMP_LOAD;
                    state_d = COMPUTE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COMPUTE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    wcnt_d  = '0;
                    state_d = SM_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SM_WAIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.sm_done) begin
                    addr_d    = '0;
                    max_val_d = '0;
                    max_idx_d = '0;
                    state_d   = SCAN;
                end else if (wcnt_q == WCNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    rsp_index_d = '0;
                    rsp_value_d = '0;
                    state_d     = RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    if (gt) begin
                        max_val_d = bus.sm_value;
                        max_idx_d = addr_q;
                    end
                    if (addr_q == CLS_LAST) begin
                        rsp_valid_d = 1'b1;
                        rsp_tmo_d   = 1'b0;
                        rsp_index_d = gt ? addr_q : max_idx_q;
                        rsp_value_d = gt ? bus.sm_value : max_val_q;
                        state_d     = RESP;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            max_val_q   <= '0;
            max_idx_q   <= '0;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_index_q <= '0;
            rsp_value_q <= '0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            max_val_q   <= max_val_d;
            max_idx_q   <= max_idx_d;
            m_q         <= m_d;
            n_q         <= n_d;
            k_q         <= k_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_index_q <= rsp_index_d;
            rsp_value_q <= rsp_value_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.dp_read_enable = (state_q == LOOKUP);
    assign bus.dp_m_index     = m_q;
    assign bus.dp_n_index     = n_q;
    assign bus.dp_k_index     = k_q;
    assign bus.sm_addr        = addr_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_index      = rsp_index_q;
    assign bus.rsp_value      = rsp_value_q;
    assign bus.rsp_timeout    = rsp_tmo_q;
endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Self-checking bench for mlp_infer_ctrl: randomized softmax contents and
// request indices checked against an argmax/latency reference model.
module tb_mlp_infer_ctrl;
    localparam int EMB = 2;
    localparam int CMP = 9;
    localparam int TMO = 1023;
    localparam int NC  = 387;

    logic clk;
    logic reset;
    mlp_infer_ctrl_if bus ();

    logic [7:0] sm_mem [0:NC-1];
    int n_checks = 0;
    int n_fail   = 0;

    mlp_infer_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.sm_value = (int'(bus.sm_addr) < NC) ? sm_mem[int'(bus.sm_addr)] : 8'd0;

    // Reference: find the maximum first, then the first index holding it.
    task automatic ref_argmax(output int idx, output int val);
        val = 0;
        for (int i = 0; i < NC; i++) if (int'(sm_mem[i]) > val) val = int'(sm_mem[i]);
        idx = -1;
        for (int i = 0; i < NC && idx < 0; i++) if (int'(sm_mem[i]) == val) idx = i;
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < NC; i++) begin
            case (mode)
                0: sm_mem[i] = 8'($urandom);
                1: sm_mem[i] = 8'($urandom_range(0, 7));
                default: sm_mem[i] = 8'd0;
            endcase
        end
    endtask

    // Drives one request; w = SM_WAIT cycles including the done cycle (0 = never).
    task automatic do_infer(input logic [9:0] m, input logic [9:0] n, input logic [9:0] k,
                            input int w, input int abort_e, input int rst_e,
                            output int lat, output int re_cnt, output int idx_bad, output bit stopped);
        int e;
        lat = -1; re_cnt = 0; idx_bad = 0; stopped = 0;
        @(negedge clk);
        bus.req_m = m; bus.req_n = n; bus.req_k = k; bus.req_valid = 1'b1;
        @(posedge clk);
        e = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_m = 10'($urandom); bus.req_n = 10'($urandom); bus.req_k = 10'($urandom);
        while (e < 3000) begin
            // e == 4 is inside COMPUTE; that pulse must be ignored.
            bus.sm_done = (e == 4) || (w > 0 && e == EMB + CMP + w - 1);
            bus.abort   = (e == abort_e);
            if (bus.dp_read_enable) begin
                re_cnt++;
                if (bus.dp_m_index !== m || bus.dp_n_index !== n || bus.dp_k_index !== k) idx_bad++;
            end
            if (e == rst_e) begin
                #2 reset = 1'b1;
                #1 stopped = 1;
                break;
            end
            if (abort_e >= 0 && e == abort_e + 1) begin stopped = 1; break; end
            if (bus.rsp_valid) begin lat = e; break; end
            @(posedge clk); e++; @(negedge clk);
        end
        bus.sm_done = 1'b0;
        bus.abort   = 1'b0;
    endtask

    task automatic finish_rsp;
        @(negedge clk) bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.dp_read_enable !== 1'b0) begin n_fail++; $display("FAIL reset_read_enable got %b want 0", bus.dp_read_enable); end
        n_checks++; if (bus.sm_addr !== 9'd0 || bus.dp_m_index !== 10'd0 || bus.rsp_index !== 9'd0)
            begin n_fail++; $display("FAIL reset_regs got addr=%0d m=%0d idx=%0d want 0", bus.sm_addr, bus.dp_m_index, bus.rsp_index); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_nominal;
        int lat, re, bad, ei, ev; bit st;
        for (int i = 0; i < NC; i++) sm_mem[i] = 8'd10;
        sm_mem[42] = 8'd200;
        ref_argmax(ei, ev);
        do_infer(10'd5, 10'd7, 10'd3, 1, -1, -1, lat, re, bad, st);
        n_checks++; if (lat !== EMB + CMP + 1 + NC) begin n_fail++; $display("FAIL nom_latency got %0d want %0d", lat, EMB + CMP + 1 + NC); end
        n_checks++; if (int'(bus.rsp_index) !== ei) begin n_fail++; $display("FAIL nom_index got %0d want %0d", bus.rsp_index, ei); end
        n_checks++; if (int'(bus.rsp_value) !== ev) begin n_fail++; $display("FAIL nom_value got %0d want %0d", bus.rsp_value, ev); end
        n_checks++; if (bus.rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL nom_timeout got %b want 0", bus.rsp_timeout); end
        n_checks++; if (re !== EMB) begin n_fail++; $display("FAIL nom_read_enable_cycles got %0d want %0d", re, EMB); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL nom_dp_index got %0d bad cycles want 0", bad); end
        finish_rsp();
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            begin n_fail++; $display("FAIL nom_release got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_edges;
        int lat, re, bad, ei, ev; bit st;
        for (int p = 0; p < 3; p++) begin
            fill_mem(2);
            if (p == 0) begin sm_mem[3] = 8'd255; sm_mem[NC-1] = 8'd255; end
            if (p == 2) sm_mem[NC-1] = 8'd1;
            ref_argmax(ei, ev);
            do_infer(10'($urandom), 10'($urandom), 10'($urandom), 1, -1, -1, lat, re, bad, st);
            n_checks++; if (int'(bus.rsp_index) !== ei || int'(bus.rsp_value) !== ev)
                begin n_fail++; $display("FAIL edge%0d got idx=%0d val=%0d want idx=%0d val=%0d", p, bus.rsp_index, bus.rsp_value, ei, ev); end
            finish_rsp();
        end
    endtask

    task automatic test_timeout;
        int lat, re, bad; bit st;
        fill_mem(0);
        do_infer(10'd1, 10'd2, 10'd3, 0, -1, -1, lat, re, bad, st);
        n_checks++; if (lat !== EMB + CMP + TMO) begin n_fail++; $display("FAIL tmo_latency got %0d want %0d", lat, EMB + CMP + TMO); end
        n_checks++; if (bus.rsp_timeout !== 1'b1 || bus.rsp_index !== 9'd0 || bus.rsp_value !== 8'd0)
            begin n_fail++; $display("FAIL tmo_result got t=%b idx=%0d val=%0d want 1/0/0", bus.rsp_timeout, bus.rsp_index, bus.rsp_value); end
        finish_rsp();
    endtask

    task automatic test_random;
        int lat, re, bad, ei, ev, w; bit st;
        for (int it = 0; it < 4; it++) begin
            fill_mem(it % 2);
            ref_argmax(ei, ev);
            w = $urandom_range(1, 30);
            do_infer(10'($urandom), 10'($urandom), 10'($urandom), w, -1, -1, lat, re, bad, st);
            n_checks++; if (lat !== EMB + CMP + w + NC) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", it, lat, EMB + CMP + w + NC); end
            n_checks++; if (int'(bus.rsp_index) !== ei || int'(bus.rsp_value) !== ev || bus.rsp_timeout !== 1'b0)
                begin n_fail++; $display("FAIL rnd%0d_result got idx=%0d val=%0d t=%b want idx=%0d val=%0d t=0", it, bus.rsp_index, bus.rsp_value, bus.rsp_timeout, ei, ev); end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rnd%0d_dp_index got %0d bad cycles want 0", it, bad); end
            finish_rsp();
        end
    endtask

    task automatic test_back_to_back;
        int lat, re, bad, ei, ev, unstable; bit st;
        logic [9:0] nm;
        fill_mem(0);
        ref_argmax(ei, ev);
        do_infer(10'd9, 10'd8, 10'd7, 2, -1, -1, lat, re, bad, st);
        unstable = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            bus.req_valid = 1'($urandom);
            bus.req_m = 10'($urandom);
            if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_index) !== ei || int'(bus.rsp_value) !== ev ||
                bus.req_ready !== 1'b0 || bus.dp_m_index !== 10'd9) unstable++;
        end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable cycles want 0", unstable); end
        nm = 10'($urandom);
        @(negedge clk);
        bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_m = nm;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL b2b_handshake got ready=%b busy=%b valid=%b want 1/0/0", bus.req_ready, bus.busy, bus.rsp_valid); end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b1 || bus.dp_m_index !== nm)
            begin n_fail++; $display("FAIL b2b_accept got busy=%b m=%0d want 1/%0d", bus.busy, bus.dp_m_index, nm); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.dp_read_enable !== 1'b0)
            begin n_fail++; $display("FAIL lookup_abort got busy=%b re=%b want 0/0", bus.busy, bus.dp_read_enable); end
    endtask

    task automatic test_abort;
        int lat, re, bad, ei, ev, seen; bit st;
        fill_mem(0);
        do_infer(10'd4, 10'd4, 10'd4, 1, EMB + CMP + 1 + 100, -1, lat, re, bad, st);
        n_checks++; if (st !== 1'b1 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL scan_abort got stop=%b busy=%b ready=%b valid=%b want 1/0/1/0", st, bus.busy, bus.req_ready, bus.rsp_valid); end
        seen = 0;
        for (int c = 0; c < 400; c++) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_rsp got %0d valid cycles want 0", seen); end
        fill_mem(0);
        ref_argmax(ei, ev);
        do_infer(10'd11, 10'd12, 10'd13, 3, -1, -1, lat, re, bad, st);
        n_checks++; if (lat !== EMB + CMP + 3 + NC || int'(bus.rsp_index) !== ei || int'(bus.rsp_value) !== ev)
            begin n_fail++; $display("FAIL after_abort got lat=%0d idx=%0d val=%0d want %0d/%0d/%0d", lat, bus.rsp_index, bus.rsp_value, EMB + CMP + 3 + NC, ei, ev); end
        finish_rsp();
    endtask

    task automatic test_async_reset;
        int lat, re, bad, ei, ev; bit st;
        fill_mem(0);
        do_infer(10'd21, 10'd22, 10'd23, 1, -1, EMB + CMP + 1 + 150, lat, re, bad, st);
        n_checks++; if (st !== 1'b1 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL async_rst_ctrl got stop=%b ready=%b busy=%b valid=%b want 1/1/0/0", st, bus.req_ready, bus.busy, bus.rsp_valid); end
        n_checks++; if (bus.sm_addr !== 9'd0 || bus.dp_m_index !== 10'd0 || bus.dp_read_enable !== 1'b0 || bus.rsp_index !== 9'd0)
            begin n_fail++; $display("FAIL async_rst_regs got addr=%0d m=%0d re=%b idx=%0d want 0", bus.sm_addr, bus.dp_m_index, bus.dp_read_enable, bus.rsp_index); end
        @(negedge clk) reset = 1'b0;
        fill_mem(1);
        ref_argmax(ei, ev);
        do_infer(10'd30, 10'd31, 10'd32, 1, -1, -1, lat, re, bad, st);
        n_checks++; if (lat !== EMB + CMP + 1 + NC || int'(bus.rsp_index) !== ei || int'(bus.rsp_value) !== ev)
            begin n_fail++; $display("FAIL after_reset got lat=%0d idx=%0d val=%0d want %0d/%0d/%0d", lat, bus.rsp_index, bus.rsp_value, EMB + CMP + 1 + NC, ei, ev); end
        finish_rsp();
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_m = '0; bus.req_n = '0; bus.req_k = '0;
        bus.abort = 1'b0; bus.sm_done = 1'b0; bus.rsp_ready = 1'b0;
        fill_mem(2);
        test_reset();
        test_nominal();
        test_edges();
        test_timeout();
        test_random();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
